// File: rtl/zx_kbd_matrix.sv
// PS/2 set-2 scan codes to ZX Spectrum 8x5 keyboard matrix, with per-key hold table.
// Define ZX_KBD_MULTIROW_EN to AND together every row selected low on A_row.
module zx_kbd_matrix #(
   parameter int unsigned HOLD_DEPTH = 8,
   parameter int unsigned ROWS       = 8,
   parameter int unsigned COLS       = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [ROWS-1:0] A_row,
   output logic [COLS-1:0] key_row,
   input  logic [7:0]      scan_code,
   input  logic            scan_code_ready,
   input  logic            scan_code_error,
   output logic            hold_overflow,
   output logic            any_key
);

   localparam int unsigned IDXW = $clog2(HOLD_DEPTH);

   typedef logic [6:0] pos_t;  // {valid, row[2:0], col[2:0]}

   localparam pos_t CAPS = 7'b1_000_000;
   localparam pos_t SYM  = 7'b1_111_001;

   function automatic pos_t pk(input logic [2:0] r, input logic [2:0] c);
      return {1'b1, r, c};
   endfunction

   // Stage 0: prefix tracking and code capture
   logic       ext_q, rel_q;
   logic       s0_vld_q, s0_ext_q, s0_rel_q;
   logic [7:0] s0_code_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ext_q     <= 1'b0;
         rel_q     <= 1'b0;
         s0_vld_q  <= 1'b0;
         s0_ext_q  <= 1'b0;
         s0_rel_q  <= 1'b0;
         s0_code_q <= '0;
      end else begin
         s0_vld_q <= 1'b0;
         if (scan_code_error) begin
            ext_q <= 1'b0;
            rel_q <= 1'b0;
         end else if (scan_code_ready) begin
            if (scan_code == 8'hE0) begin
               ext_q <= 1'b1;
            end else if (scan_code == 8'hF0) begin
               rel_q <= 1'b1;
            end else begin
               s0_vld_q  <= 1'b1;
               s0_code_q <= scan_code;
               s0_ext_q  <= ext_q;
               s0_rel_q  <= rel_q;
               ext_q     <= 1'b0;
               rel_q     <= 1'b0;
            end
         end
      end
   end

   // Stage 1: decode to up to two matrix positions
   logic shifted_q;
   logic dec_shift;
   pos_t dec_p0, dec_p1;

   always_comb begin
      dec_p0    = '0;
      dec_p1    = '0;
      dec_shift = 1'b0;
      if (s0_ext_q) begin
         case (s0_code_q)
            8'h14: dec_p0 = CAPS;
            8'h11: dec_p0 = SYM;
            8'h6B: begin dec_p0 = CAPS; dec_p1 = pk(3'd3, 3'd4); end
            8'h72: begin dec_p0 = CAPS; dec_p1 = pk(3'd4, 3'd4); end
            8'h75: begin dec_p0 = CAPS; dec_p1 = pk(3'd4, 3'd3); end
            8'h74: begin dec_p0 = CAPS; dec_p1 = pk(3'd4, 3'd2); end
            default: ;
         endcase
      end else begin
         case (s0_code_q)
            8'h12, 8'h59: dec_shift = 1'b1;
            8'h14: dec_p0 = CAPS;
            8'h11: dec_p0 = SYM;
            8'h1A: dec_p0 = pk(3'd0, 3'd1);
            8'h22: dec_p0 = pk(3'd0, 3'd2);
            8'h21: dec_p0 = pk(3'd0, 3'd3);
            8'h2A: dec_p0 = pk(3'd0, 3'd4);
            8'h1C: dec_p0 = pk(3'd1, 3'd0);
            8'h1B: dec_p0 = pk(3'd1, 3'd1);
            8'h23: dec_p0 = pk(3'd1, 3'd2);
            8'h2B: dec_p0 = pk(3'd1, 3'd3);
            8'h34: dec_p0 = pk(3'd1, 3'd4);
            8'h15: dec_p0 = pk(3'd2, 3'd0);
            8'h1D: dec_p0 = pk(3'd2, 3'd1);
            8'h24: dec_p0 = pk(3'd2, 3'd2);
            8'h2D: dec_p0 = pk(3'd2, 3'd3);
            8'h2C: dec_p0 = pk(3'd2, 3'd4);
            8'h16: dec_p0 = pk(3'd3, 3'd0);
            8'h1E: dec_p0 = pk(3'd3, 3'd1);
            8'h26: dec_p0 = pk(3'd3, 3'd2);
            8'h25: dec_p0 = pk(3'd3, 3'd3);
            8'h2E: dec_p0 = pk(3'd3, 3'd4);
            8'h45: dec_p0 = pk(3'd4, 3'd0);
            8'h46: dec_p0 = pk(3'd4, 3'd1);
            8'h3E: dec_p0 = pk(3'd4, 3'd2);
            8'h3D: dec_p0 = pk(3'd4, 3'd3);
            8'h36: dec_p0 = pk(3'd4, 3'd4);
            8'h4D: dec_p0 = pk(3'd5, 3'd0);
            8'h44: dec_p0 = pk(3'd5, 3'd1);
            8'h43: dec_p0 = pk(3'd5, 3'd2);
            8'h3C: dec_p0 = pk(3'd5, 3'd3);
            8'h35: dec_p0 = pk(3'd5, 3'd4);
            8'h5A: dec_p0 = pk(3'd6, 3'd0);
            8'h4B: dec_p0 = pk(3'd6, 3'd1);
            8'h42: dec_p0 = pk(3'd6, 3'd2);
            8'h3B: dec_p0 = pk(3'd6, 3'd3);
            8'h33: dec_p0 = pk(3'd6, 3'd4);
            8'h29: dec_p0 = pk(3'd7, 3'd0);
            8'h3A: dec_p0 = pk(3'd7, 3'd2);
            8'h31: dec_p0 = pk(3'd7, 3'd3);
            8'h32: dec_p0 = pk(3'd7, 3'd4);
            8'h66: begin dec_p0 = CAPS; dec_p1 = pk(3'd4, 3'd0); end
            8'h76: begin dec_p0 = CAPS; dec_p1 = pk(3'd7, 3'd0); end
            // Punctuation: symbol-shift plus a key that depends on PC shift state
            8'h4E: begin dec_p0 = SYM; dec_p1 = shifted_q ? pk(3'd4, 3'd0) : pk(3'd6, 3'd3); end
            8'h55: begin dec_p0 = SYM; dec_p1 = shifted_q ? pk(3'd6, 3'd2) : pk(3'd6, 3'd1); end
            8'h52: begin dec_p0 = SYM; dec_p1 = shifted_q ? pk(3'd5, 3'd0) : pk(3'd4, 3'd3); end
            8'h4C: begin dec_p0 = SYM; dec_p1 = shifted_q ? pk(3'd0, 3'd1) : pk(3'd5, 3'd1); end
            8'h41: begin dec_p0 = SYM; dec_p1 = shifted_q ? pk(3'd2, 3'd3) : pk(3'd7, 3'd3); end
            8'h49: begin dec_p0 = SYM; dec_p1 = shifted_q ? pk(3'd2, 3'd4) : pk(3'd7, 3'd2); end
            8'h4A: begin dec_p0 = SYM; dec_p1 = shifted_q ? pk(3'd0, 3'd3) : pk(3'd0, 3'd4); end
            default: ;
         endcase
      end
   end

   logic       s1_vld_q, s1_rel_q;
   logic [8:0] s1_key_q;
   pos_t       s1_p0_q, s1_p1_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shifted_q <= 1'b0;
         s1_vld_q  <= 1'b0;
         s1_rel_q  <= 1'b0;
         s1_key_q  <= '0;
         s1_p0_q   <= '0;
         s1_p1_q   <= '0;
      end else begin
         s1_vld_q <= s0_vld_q && !dec_shift;
         if (s0_vld_q && dec_shift) begin
            shifted_q <= !s0_rel_q;
         end
         if (s0_vld_q) begin
            s1_key_q <= {s0_ext_q, s0_code_q};
            s1_rel_q <= s0_rel_q;
            s1_p0_q  <= dec_p0;
            s1_p1_q  <= dec_p1;
         end
      end
   end

   // Stage 2: hold table
   logic [HOLD_DEPTH-1:0] ent_vld_q;
   logic [8:0]            ent_key_q [HOLD_DEPTH];
   pos_t                  ent_p0_q  [HOLD_DEPTH];
   pos_t                  ent_p1_q  [HOLD_DEPTH];
   logic                  hit, free_found, overflow_q;
   logic [IDXW-1:0]       hit_idx, free_idx;

   always_comb begin
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int unsigned i = 0; i < HOLD_DEPTH; i++) begin
         if (ent_vld_q[i] && ent_key_q[i] == s1_key_q) begin
            hit     = 1'b1;
            hit_idx = IDXW'(i);
         end
         if (!free_found && !ent_vld_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDXW'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ent_vld_q  <= '0;
         overflow_q <= 1'b0;
         for (int unsigned i = 0; i < HOLD_DEPTH; i++) begin
            ent_key_q[i] <= '0;
            ent_p0_q[i]  <= '0;
            ent_p1_q[i]  <= '0;
         end
      end else if (s1_vld_q) begin
         if (!s1_rel_q) begin
            // Unmapped codes and typematic repeats take no entry
            if (!hit && s1_p0_q[6]) begin
               if (free_found) begin
                  ent_vld_q[free_idx] <= 1'b1;
                  ent_key_q[free_idx] <= s1_key_q;
                  ent_p0_q[free_idx]  <= s1_p0_q;
                  ent_p1_q[free_idx]  <= s1_p1_q;
               end else begin
                  overflow_q <= 1'b1;
               end
            end
         end else if (hit) begin
            ent_vld_q[hit_idx] <= 1'b0;
         end
      end
   end

   // Stage 3: matrix register, active-low
   logic [4:0] mat_d [8];
   logic [4:0] mat_q [8];

   always_comb begin
      for (int unsigned r = 0; r < 8; r++) begin
         mat_d[r] = '1;
      end
      for (int unsigned i = 0; i < HOLD_DEPTH; i++) begin
         if (ent_vld_q[i]) begin
            if (ent_p0_q[i][6]) mat_d[ent_p0_q[i][5:3]][ent_p0_q[i][2:0]] = 1'b0;
            if (ent_p1_q[i][6]) mat_d[ent_p1_q[i][5:3]][ent_p1_q[i][2:0]] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned r = 0; r < 8; r++) begin
            mat_q[r] <= '1;
         end
      end else begin
         for (int unsigned r = 0; r < 8; r++) begin
            mat_q[r] <= mat_d[r];
         end
      end
   end

   // Read path
   logic [COLS-1:0] row_bits [ROWS];
   logic [ROWS-1:0] sel;

   assign sel = ~A_row;

   always_comb begin
      for (int unsigned r = 0; r < ROWS; r++) begin
         row_bits[r] = '1;
         if (r < 8) row_bits[r][4:0] = mat_q[r[2:0]];
      end
   end

   always_comb begin
      key_row = '1;
`ifdef ZX_KBD_MULTIROW_EN
      for (int unsigned r = 0; r < ROWS; r++) begin
         if (sel[r]) key_row = key_row & row_bits[r];
      end
`else
      if (sel != '0 && (sel & (sel - ROWS'(1))) == '0) begin
         for (int unsigned r = 0; r < ROWS; r++) begin
            if (sel[r]) key_row = row_bits[r];
         end
      end
`endif
   end

   assign hold_overflow = overflow_q;
   assign any_key       = |ent_vld_q;

endmodule

// File: tb/tb_zx_kbd_matrix.sv
// Directed vector bench for zx_kbd_matrix: table of scan codes with expected row reads,
// plus hand sequences for latency, overflow, error, multi-row and mid-sequence reset.
module tb_zx_kbd_matrix;

   localparam int unsigned HD = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] A_row;
   logic [4:0] key_row;
   logic [7:0] scan_code;
   logic       scan_code_ready;
   logic       scan_code_error;
   logic       hold_overflow;
   logic       any_key;

   always #5 clk = ~clk;

   zx_kbd_matrix #(
      .HOLD_DEPTH (HD),
      .ROWS       (8),
      .COLS       (5)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .A_row           (A_row),
      .key_row         (key_row),
      .scan_code       (scan_code),
      .scan_code_ready (scan_code_ready),
      .scan_code_error (scan_code_error),
      .hold_overflow   (hold_overflow),
      .any_key         (any_key)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       strobe;
      logic [7:0] code;
      logic [7:0] a_row;
      logic [4:0] exp_row;
      logic       exp_any;
   } vec_t;

   vec_t vecs[$];

   logic [7:0] ovf_keys [9] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h1C, 8'h1B, 8'h23, 8'h1A};
   logic [7:0] rel_seq  [6] = '{8'hF0, 8'h1B, 8'hF0, 8'h23, 8'hF0, 8'h2B};

   function automatic void add(input logic s, input logic [7:0] c, input logic [7:0] a,
                               input logic [4:0] r, input logic k);
      vec_t v;
      v.strobe  = s;
      v.code    = c;
      v.a_row   = a;
      v.exp_row = r;
      v.exp_any = k;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] c);
      @(negedge clk);
      scan_code       = c;
      scan_code_ready = 1'b1;
      @(negedge clk);
      scan_code_ready = 1'b0;
   endtask

   task automatic settle();
      repeat (3) @(negedge clk);
   endtask

   task automatic read_row(input string nm, input logic [7:0] a, input logic [4:0] exp);
      A_row = a;
      #1;
      chk(nm, {3'b000, key_row}, {3'b000, exp});
   endtask

   initial begin
      // Running state through the table; each vector settles for the full pipeline
      add(1, 8'h1C, 8'hFD, 5'b11110, 1);
      add(0, 8'h00, 8'hFE, 5'b11111, 1);
      add(1, 8'hF0, 8'hFD, 5'b11110, 1);
      add(1, 8'h1C, 8'hFD, 5'b11111, 0);
      add(1, 8'h14, 8'hFE, 5'b11110, 1);
      add(1, 8'h66, 8'hFE, 5'b11110, 1);
      add(0, 8'h00, 8'hEF, 5'b11110, 1);
      add(1, 8'hF0, 8'hFE, 5'b11110, 1);
      add(1, 8'h66, 8'hFE, 5'b11110, 1);
      add(0, 8'h00, 8'hEF, 5'b11111, 1);
      add(1, 8'hF0, 8'hFE, 5'b11110, 1);
      add(1, 8'h14, 8'hFE, 5'b11111, 0);
      add(1, 8'h12, 8'hFF, 5'b11111, 0);
      add(1, 8'h4E, 8'hEF, 5'b11110, 1);
      add(0, 8'h00, 8'hBF, 5'b11111, 1);
      add(0, 8'h00, 8'h7F, 5'b11101, 1);
      add(1, 8'hF0, 8'h7F, 5'b11101, 1);
      add(1, 8'h12, 8'h7F, 5'b11101, 1);
      add(1, 8'hF0, 8'hEF, 5'b11110, 1);
      add(1, 8'h4E, 8'hEF, 5'b11111, 0);
      add(0, 8'h00, 8'h7F, 5'b11111, 0);
      for (int i = 0; i < 5; i++) add(1, 8'h1C, 8'hFD, 5'b11110, 1);
      add(1, 8'hF0, 8'hFD, 5'b11110, 1);
      add(1, 8'h1C, 8'hFD, 5'b11111, 0);
      add(1, 8'h4E, 8'hBF, 5'b10111, 1);
      add(0, 8'h00, 8'h7F, 5'b11101, 1);
      add(1, 8'h12, 8'hBF, 5'b10111, 1);
      add(1, 8'hF0, 8'hBF, 5'b10111, 1);
      add(1, 8'h4E, 8'hBF, 5'b11111, 0);
      add(1, 8'hF0, 8'hFF, 5'b11111, 0);
      add(1, 8'h12, 8'hFF, 5'b11111, 0);
      add(1, 8'hE0, 8'hFE, 5'b11111, 0);
      add(1, 8'h75, 8'hFE, 5'b11110, 1);
      add(0, 8'h00, 8'hEF, 5'b10111, 1);
      add(1, 8'hE0, 8'hEF, 5'b10111, 1);
      add(1, 8'hF0, 8'hEF, 5'b10111, 1);
      add(1, 8'h75, 8'hEF, 5'b11111, 0);

      reset           = 1'b0;
      A_row           = 8'hFF;
      scan_code       = 8'h00;
      scan_code_ready = 1'b0;
      scan_code_error = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      chk("rst_overflow", {7'b0, hold_overflow}, 8'h00);
      chk("rst_any", {7'b0, any_key}, 8'h00);
      read_row("rst_row0", 8'hFE, 5'b11111);
      read_row("rst_row1", 8'hFD, 5'b11111);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].strobe) begin
            send(vecs[i].code);
            settle();
         end
         read_row($sformatf("vec%0d_row", i), vecs[i].a_row, vecs[i].exp_row);
         chk($sformatf("vec%0d_any", i), {7'b0, any_key}, {7'b0, vecs[i].exp_any});
      end

      // Latency: visible after the third edge following the strobe, not before
      send(8'h1B);
      A_row = 8'hFD;
      repeat (2) @(negedge clk);
      #1 chk("lat_early", {3'b0, key_row}, 8'b000_11111);
      @(negedge clk);
      #1 chk("lat_on_time", {3'b0, key_row}, 8'b000_11101);

      // Strobes on consecutive cycles
      @(negedge clk);
      scan_code       = 8'h23;
      scan_code_ready = 1'b1;
      @(negedge clk);
      scan_code = 8'h2B;
      @(negedge clk);
      scan_code_ready = 1'b0;
      settle();
      read_row("b2b_press", 8'hFD, 5'b10001);
      for (int i = 0; i < 6; i++) begin
         scan_code       = rel_seq[i];
         scan_code_ready = 1'b1;
         @(negedge clk);
      end
      scan_code_ready = 1'b0;
      settle();
      read_row("b2b_release", 8'hFD, 5'b11111);
      chk("b2b_any", {7'b0, any_key}, 8'h00);

      // Table overflow: the ninth distinct key is dropped
      for (int i = 0; i < HD + 1; i++) send(ovf_keys[i]);
      settle();
      chk("ovf_flag", {7'b0, hold_overflow}, 8'h01);
      read_row("ovf_last_absent", 8'hFE, 5'b11111);
      read_row("ovf_row2", 8'hFB, 5'b00000);
      read_row("ovf_row1", 8'hFD, 5'b11000);
      for (int i = 0; i < HD; i++) begin
         send(8'hF0);
         send(ovf_keys[i]);
      end
      settle();
      chk("ovf_released_any", {7'b0, any_key}, 8'h00);
      chk("ovf_sticky", {7'b0, hold_overflow}, 8'h01);

      // Receive error clears a pending E0 and swallows a concurrent strobe
      send(8'hE0);
      scan_code_error = 1'b1;
      @(negedge clk);
      scan_code_error = 1'b0;
      send(8'h74);
      settle();
      read_row("err_prefix", 8'hFE, 5'b11111);
      chk("err_prefix_any", {7'b0, any_key}, 8'h00);
      scan_code       = 8'h1C;
      scan_code_ready = 1'b1;
      scan_code_error = 1'b1;
      @(negedge clk);
      scan_code_ready = 1'b0;
      scan_code_error = 1'b0;
      settle();
      read_row("err_strobe", 8'hFD, 5'b11111);
      chk("err_strobe_any", {7'b0, any_key}, 8'h00);

      // Multi-row read with A and Z held
      send(8'h1C);
      send(8'h1A);
      settle();
`ifdef ZX_KBD_MULTIROW_EN
      read_row("multirow_fc", 8'hFC, 5'b11100);
`else
      read_row("multirow_fc", 8'hFC, 5'b11111);
`endif
      read_row("multirow_all", 8'hFF, 5'b11111);

      // Reset with entries held and an E0 pending
      send(8'hE0);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_any", {7'b0, any_key}, 8'h00);
      chk("midrst_overflow", {7'b0, hold_overflow}, 8'h00);
      read_row("midrst_row1", 8'hFD, 5'b11111);
      send(8'h74);
      settle();
      read_row("midrst_74_row0", 8'hFE, 5'b11111);
      read_row("midrst_74_row4", 8'hEF, 5'b11111);
      chk("midrst_74_any", {7'b0, any_key}, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
